// File: rtl/fft_bf_sched.sv
// fft_bf_sched: radix-2 DIT FFT butterfly scheduler and twiddle reader.
// Walks every stage s and butterfly j of an N-point transform, drives the
// twiddle ROM index, absorbs the ROM's one-cycle registered latency and emits
// one butterfly command per beat over a valid/ready handshake.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 begin transform (sampled in IDLE only)
//   i_inverse               conjugate twiddles for inverse FFT (FFT_TW_CONJ_EN only)
//   o_busy, o_done          run in progress / one-cycle completion pulse
//   o_tw_idx                ROM read index
//   i_tw_re, i_tw_im        ROM outputs, valid one cycle after o_tw_idx
//   o_bf_valid, i_bf_ready  command handshake
//   o_bf_addr_a/b, o_bf_stage, o_bf_last, o_bf_w_re/im  command fields
// Optional feature macro: FFT_TW_CONJ_EN.
module fft_bf_sched #(
    parameter int N = 4096,
    parameter int LOG_N = $clog2(N),
    parameter int TW_W = $clog2(N / 2),
    parameter int K = 16,
    localparam int SW = $clog2(LOG_N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
`ifdef FFT_TW_CONJ_EN
    input  logic             i_inverse,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [TW_W-1:0]  o_tw_idx,
    input  logic [K-1:0]     i_tw_re,
    input  logic [K-1:0]     i_tw_im,
    output logic             o_bf_valid,
    input  logic             i_bf_ready,
    output logic [LOG_N-1:0] o_bf_addr_a,
    output logic [LOG_N-1:0] o_bf_addr_b,
    output logic [SW-1:0]    o_bf_stage,
    output logic             o_bf_last,
    output logic [K-1:0]     o_bf_w_re,
    output logic [K-1:0]     o_bf_w_im
);
    localparam int MW = 2 * LOG_N + SW + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t r_st, w_st_n;
    logic [SW-1:0] r_s;
    logic [TW_W-1:0] r_j;
    logic [MW-1:0] r_m, w_m, r_out_m, r_skid_m;
    logic [K-1:0] r_out_re, r_out_im, r_skid_re, r_skid_im, w_im;
    logic r_ov, r_sv, r_inf, r_done;
    logic [LOG_N-1:0] w_half, w_pos, w_grp, w_a, w_b;
    logic w_last, w_fin, w_pop, w_iss, w_drained;
    logic [1:0] w_cnt;
`ifdef FFT_TW_CONJ_EN
    logic r_inv;
`endif
    always_comb begin
        w_half = LOG_N'(1) << r_s;
        w_pos = {1'b0, r_j} & (w_half - LOG_N'(1));
        w_grp = {1'b0, r_j} >> r_s;
        w_a = ((w_grp << r_s) << 1) | w_pos;
        w_b = w_a + w_half;
        w_last = &r_j;
        w_fin = w_last && (r_s == SW'(LOG_N - 1));
        w_m = {w_a, w_b, r_s, w_last};
        o_tw_idx = TW_W'(w_pos << (TW_W - r_s));
        w_pop = r_ov && i_bf_ready;
        // occupancy after this edge's pop; an issue only fits while it stays below two
        w_cnt = 2'(r_inf) + 2'(r_ov) + 2'(r_sv) - 2'(w_pop);
        w_iss = (r_st == RUN) && (w_cnt < 2'd2);
        w_drained = (r_st == DRAIN) && !r_inf && !r_sv && w_pop;
        w_st_n = (r_st == IDLE && i_start) ? RUN :
                 (w_iss && w_fin) ? DRAIN :
                 w_drained ? IDLE : r_st;
`ifdef FFT_TW_CONJ_EN
        w_im = !r_inv ? i_tw_im :
               (i_tw_im == {1'b1, {(K-1){1'b0}}}) ? {1'b0, {(K-1){1'b1}}} : -i_tw_im;
`else
        w_im = i_tw_im;
`endif
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_st <= IDLE;
        else r_st <= w_st_n;
`ifdef FFT_TW_CONJ_EN
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_inv <= 1'b0;
        else if (r_st == IDLE && i_start) r_inv <= i_inverse;
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s <= '0;
            r_j <= '0;
            r_m <= '0;
            r_inf <= 1'b0;
            r_done <= 1'b0;
            r_ov <= 1'b0;
            r_sv <= 1'b0;
            r_out_m <= '0;
            r_out_re <= '0;
            r_out_im <= '0;
            r_skid_m <= '0;
            r_skid_re <= '0;
            r_skid_im <= '0;
        end else begin
            r_done <= w_drained;
            r_inf <= w_iss;
            if (w_iss) r_m <= w_m;
            // counters freeze on the final issue so the ROM index holds through DRAIN
            if (w_drained) begin
                r_s <= '0;
                r_j <= '0;
            end else if (w_iss && !w_fin) begin
                r_j <= r_j + TW_W'(1);
                r_s <= r_s + SW'(w_last);
            end
            if (!r_ov || w_pop) begin
                r_ov <= r_sv || r_inf;
                r_sv <= r_sv && r_inf;
                if (r_sv) {r_out_m, r_out_re, r_out_im} <= {r_skid_m, r_skid_re, r_skid_im};
                else if (r_inf) {r_out_m, r_out_re, r_out_im} <= {r_m, i_tw_re, w_im};
                if (r_sv && r_inf) {r_skid_m, r_skid_re, r_skid_im} <= {r_m, i_tw_re, w_im};
            end else if (r_inf) begin
                r_sv <= 1'b1;
                {r_skid_m, r_skid_re, r_skid_im} <= {r_m, i_tw_re, w_im};
            end
        end
    end
    assign o_busy = (r_st != IDLE);
    assign o_done = r_done;
    assign o_bf_valid = r_ov;
    assign {o_bf_addr_a, o_bf_addr_b, o_bf_stage, o_bf_last} = r_out_m;
    assign o_bf_w_re = r_out_re;
    assign o_bf_w_im = r_out_im;
endmodule
